// File: rtl/hood_mode_scheduler.sv
// Range-hood fan mode scheduler: mode FSM with per-second timers for hurricane,
// self-clean and cooldown, driving fan level and the clean actuator.
module hood_mode_scheduler #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned HURRICANE_SEC = 60,
  parameter int unsigned CLEAN_SEC     = 180,
  parameter int unsigned COOLDOWN_SEC  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power_state,
  input  logic       menu_key,
  input  logic       level1_key,
  input  logic       level2_key,
  input  logic       level3_key,
  input  logic       clean_key,
  output logic [2:0] mode,
  output logic [1:0] fan_level,
  output logic       clean_active,
  output logic [7:0] sec_left,
  output logic       hurricane_used,
  output logic       clean_done
);

  localparam int unsigned TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_STANDBY   = 3'd1,
    S_MENU      = 3'd2,
    S_L1        = 3'd3,
    S_L2        = 3'd4,
    S_HURRICANE = 3'd5,
    S_CLEAN     = 3'd6,
    S_COOLDOWN  = 3'd7
  } mode_t;

  mode_t          state, state_d;
  logic [TW-1:0]  tick_cnt, tick_d;
  logic [7:0]     sec_d;
  logic           hu_d;
  logic           done_d;
  logic [1:0]     fan_d;
  logic           clean_d;
  logic           timed;

  assign mode = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_OFF;
      tick_cnt       <= '0;
      sec_left       <= '0;
      hurricane_used <= 1'b0;
      clean_done     <= 1'b0;
      fan_level      <= '0;
      clean_active   <= 1'b0;
    end else begin
      state          <= state_d;
      tick_cnt       <= tick_d;
      sec_left       <= sec_d;
      hurricane_used <= hu_d;
      clean_done     <= done_d;
      fan_level      <= fan_d;
      clean_active   <= clean_d;
    end
  end

  always_comb begin
    state_d = state;
    tick_d  = tick_cnt;
    sec_d   = sec_left;
    hu_d    = hurricane_used;
    done_d  = 1'b0;
    timed   = (state == S_HURRICANE) || (state == S_CLEAN) || (state == S_COOLDOWN);

    if (timed) begin
      if (tick_cnt == TICK_MAX) begin
        tick_d = '0;
        if (sec_left != '0) sec_d = sec_left - 8'd1;
      end else begin
        tick_d = tick_cnt + 1'b1;
      end
    end else begin
      tick_d = '0;
      sec_d  = '0;
    end

    case (state)
      S_OFF:     state_d = S_STANDBY;
      S_STANDBY: if (menu_key) state_d = S_MENU;
      S_MENU: begin
        // A consumed hurricane falls through so lower-priority keys still act
        if (clean_key) begin
          state_d = S_CLEAN;
          sec_d   = 8'(CLEAN_SEC);
          tick_d  = '0;
        end else if (level3_key && !hurricane_used) begin
          state_d = S_HURRICANE;
          sec_d   = 8'(HURRICANE_SEC);
          tick_d  = '0;
          hu_d    = 1'b1;
        end else if (level2_key) begin
          state_d = S_L2;
        end else if (level1_key) begin
          state_d = S_L1;
        end else if (menu_key) begin
          state_d = S_STANDBY;
        end
      end
      S_L1: begin
        if (level2_key)    state_d = S_L2;
        else if (menu_key) state_d = S_STANDBY;
      end
      S_L2: begin
        if (level1_key)    state_d = S_L1;
        else if (menu_key) state_d = S_STANDBY;
      end
      S_HURRICANE: begin
        if (sec_left == '0) begin
          state_d = S_L2;
          sec_d   = '0;
          tick_d  = '0;
        end else if (menu_key) begin
          state_d = S_COOLDOWN;
          sec_d   = 8'(COOLDOWN_SEC);
          tick_d  = '0;
        end
      end
      S_COOLDOWN: begin
        if (sec_left == '0) begin
          state_d = S_STANDBY;
          sec_d   = '0;
          tick_d  = '0;
        end
      end
      S_CLEAN: begin
        if (sec_left == '0) begin
          state_d = S_STANDBY;
          sec_d   = '0;
          tick_d  = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_OFF;
    endcase

    if (!power_state) begin
      state_d = S_OFF;
      sec_d   = '0;
      tick_d  = '0;
      hu_d    = 1'b0;
      done_d  = 1'b0;
    end

    case (state_d)
      S_L1:                   fan_d = 2'd1;
      S_L2:                   fan_d = 2'd2;
      S_HURRICANE, S_COOLDOWN: fan_d = 2'd3;
      default:                fan_d = 2'd0;
    endcase
    clean_d = (state_d == S_CLEAN);
  end

endmodule

// File: tb/tb_hood_mode_scheduler.sv
// Directed self-checking bench for hood_mode_scheduler with short timers.
module tb_hood_mode_scheduler;

  logic       clk, reset, power_state;
  logic       menu_key, level1_key, level2_key, level3_key, clean_key;
  logic [2:0] mode;
  logic [1:0] fan_level;
  logic       clean_active;
  logic [7:0] sec_left;
  logic       hurricane_used, clean_done;

  int n_checks = 0;
  int n_fail   = 0;

  hood_mode_scheduler #(
    .TICKS_PER_SEC(4),
    .HURRICANE_SEC(3),
    .CLEAN_SEC(2),
    .COOLDOWN_SEC(2)
  ) dut (
    .clk(clk), .reset(reset), .power_state(power_state),
    .menu_key(menu_key), .level1_key(level1_key), .level2_key(level2_key),
    .level3_key(level3_key), .clean_key(clean_key),
    .mode(mode), .fan_level(fan_level), .clean_active(clean_active),
    .sec_left(sec_left), .hurricane_used(hurricane_used), .clean_done(clean_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a key combination for exactly one active edge, then release.
  task automatic keys(input logic m, input logic l1, input logic l2,
                      input logic l3, input logic c);
    menu_key = m; level1_key = l1; level2_key = l2; level3_key = l3; clean_key = c;
    tick();
    menu_key = 0; level1_key = 0; level2_key = 0; level3_key = 0; clean_key = 0;
  endtask

  task automatic test_reset();
    reset = 0; power_state = 0;
    menu_key = 0; level1_key = 0; level2_key = 0; level3_key = 0; clean_key = 0;
    #3;
    if ({mode, fan_level, clean_active, sec_left, hurricane_used, clean_done} !== 16'h0) begin
      $display("FAIL reset_outputs: got mode=%0d fan=%0d ca=%0d sec=%0d hu=%0d cd=%0d expected all 0",
               mode, fan_level, clean_active, sec_left, hurricane_used, clean_done);
      n_fail++;
    end
    n_checks++;
    #4 reset = 1;
    tick();
    if (mode !== 3'd0) begin $display("FAIL off_hold: mode=%0d expected 0", mode); n_fail++; end
    n_checks++;
  endtask

  task automatic test_power_menu();
    power_state = 1;
    tick();
    if (mode !== 3'd1) begin $display("FAIL power_on: mode=%0d expected 1", mode); n_fail++; end
    n_checks++;
    keys(0, 1, 0, 0, 0);
    if (mode !== 3'd1) begin $display("FAIL standby_ignore: mode=%0d expected 1", mode); n_fail++; end
    n_checks++;
    keys(1, 0, 0, 0, 0);
    if (mode !== 3'd2 || fan_level !== 2'd0) begin
      $display("FAIL menu_enter: mode=%0d fan=%0d expected 2/0", mode, fan_level); n_fail++;
    end
    n_checks++;
    keys(0, 1, 0, 0, 0);
    if (mode !== 3'd3 || fan_level !== 2'd1) begin
      $display("FAIL level1: mode=%0d fan=%0d expected 3/1", mode, fan_level); n_fail++;
    end
    n_checks++;
    keys(0, 0, 0, 1, 1);
    if (mode !== 3'd3) begin $display("FAIL l1_ignore: mode=%0d expected 3", mode); n_fail++; end
    n_checks++;
    keys(0, 0, 1, 0, 0);
    if (mode !== 3'd4 || fan_level !== 2'd2) begin
      $display("FAIL level2: mode=%0d fan=%0d expected 4/2", mode, fan_level); n_fail++;
    end
    n_checks++;
    keys(1, 0, 0, 0, 0);
    if (mode !== 3'd1 || fan_level !== 2'd0) begin
      $display("FAIL l2_to_standby: mode=%0d fan=%0d expected 1/0", mode, fan_level); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_hurricane_expiry();
    logic [2:0] em;
    logic [7:0] es;
    keys(1, 0, 0, 0, 0);
    keys(0, 0, 0, 1, 0);
    if (mode !== 3'd5 || fan_level !== 2'd3 || sec_left !== 8'd3 || hurricane_used !== 1'b1) begin
      $display("FAIL hurr_enter: mode=%0d fan=%0d sec=%0d hu=%0d expected 5/3/3/1",
               mode, fan_level, sec_left, hurricane_used); n_fail++;
    end
    n_checks++;
    for (int i = 1; i <= 13; i++) begin
      if (i == 6) keys(0, 1, 0, 0, 1); else tick();
      em = (i < 13) ? 3'd5 : 3'd4;
      es = (i < 13) ? 8'(3 - i / 4) : 8'd0;
      if (mode !== em || sec_left !== es) begin
        $display("FAIL hurr_run[%0d]: mode=%0d sec=%0d expected %0d/%0d", i, mode, sec_left, em, es);
        n_fail++;
      end
      n_checks++;
    end
    if (fan_level !== 2'd2 || hurricane_used !== 1'b1) begin
      $display("FAIL hurr_expired: fan=%0d hu=%0d expected 2/1", fan_level, hurricane_used); n_fail++;
    end
    n_checks++;
    keys(1, 0, 0, 0, 0);
    keys(1, 0, 0, 0, 0);
    keys(0, 0, 0, 1, 0);
    if (mode !== 3'd2) begin $display("FAIL hurr_reuse: mode=%0d expected 2", mode); n_fail++; end
    n_checks++;
    keys(0, 0, 1, 1, 0);
    if (mode !== 3'd4) begin $display("FAIL hurr_fallthrough: mode=%0d expected 4", mode); n_fail++; end
    n_checks++;
    keys(1, 0, 0, 0, 0);
  endtask

  task automatic test_hurricane_early();
    logic [2:0] em;
    logic [7:0] es;
    logic [1:0] ef;
    power_state = 0;
    tick();
    power_state = 1;
    tick();
    keys(1, 0, 0, 0, 0);
    keys(0, 0, 0, 1, 0);
    tick();
    tick();
    keys(1, 0, 0, 0, 0);
    if (mode !== 3'd7 || sec_left !== 8'd2 || fan_level !== 2'd3) begin
      $display("FAIL cool_enter: mode=%0d sec=%0d fan=%0d expected 7/2/3", mode, sec_left, fan_level);
      n_fail++;
    end
    n_checks++;
    for (int i = 1; i <= 9; i++) begin
      case (i)
        3:       keys(0, 1, 0, 0, 0);
        5:       keys(1, 0, 0, 0, 0);
        6:       keys(0, 0, 1, 1, 1);
        default: tick();
      endcase
      em = (i < 9) ? 3'd7 : 3'd1;
      es = (i < 9) ? 8'(2 - i / 4) : 8'd0;
      ef = (i < 9) ? 2'd3 : 2'd0;
      if (mode !== em || sec_left !== es || fan_level !== ef) begin
        $display("FAIL cool_run[%0d]: mode=%0d sec=%0d fan=%0d expected %0d/%0d/%0d",
                 i, mode, sec_left, fan_level, em, es, ef);
        n_fail++;
      end
      n_checks++;
    end
    if (hurricane_used !== 1'b1) begin
      $display("FAIL cool_hu: hu=%0d expected 1", hurricane_used); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_clean();
    logic [2:0] em;
    logic       ea, ed;
    keys(1, 0, 0, 0, 0);
    keys(0, 0, 0, 0, 1);
    if (mode !== 3'd6 || clean_active !== 1'b1 || sec_left !== 8'd2 || fan_level !== 2'd0) begin
      $display("FAIL clean_enter: mode=%0d ca=%0d sec=%0d fan=%0d expected 6/1/2/0",
               mode, clean_active, sec_left, fan_level); n_fail++;
    end
    n_checks++;
    for (int i = 1; i <= 9; i++) begin
      if (i == 2) keys(0, 0, 0, 1, 0);
      else if (i == 4) keys(1, 0, 0, 0, 0);
      else tick();
      em = (i < 9) ? 3'd6 : 3'd1;
      ea = (i < 9);
      ed = (i == 9);
      if (mode !== em || clean_active !== ea || clean_done !== ed) begin
        $display("FAIL clean_run[%0d]: mode=%0d ca=%0d cd=%0d expected %0d/%0d/%0d",
                 i, mode, clean_active, clean_done, em, ea, ed);
        n_fail++;
      end
      n_checks++;
    end
    tick();
    if (clean_done !== 1'b0 || mode !== 3'd1) begin
      $display("FAIL clean_done_width: cd=%0d mode=%0d expected 0/1", clean_done, mode); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_abort();
    keys(1, 0, 0, 0, 0);
    keys(0, 0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) tick();
    if (mode !== 3'd6 || sec_left !== 8'd1) begin
      $display("FAIL abort_pre: mode=%0d sec=%0d expected 6/1", mode, sec_left); n_fail++;
    end
    n_checks++;
    power_state = 0;
    keys(1, 0, 0, 0, 0);
    if (mode !== 3'd0 || clean_active !== 1'b0 || sec_left !== 8'd0 ||
        clean_done !== 1'b0 || hurricane_used !== 1'b0) begin
      $display("FAIL abort: mode=%0d ca=%0d sec=%0d cd=%0d hu=%0d expected 0/0/0/0/0",
               mode, clean_active, sec_left, clean_done, hurricane_used); n_fail++;
    end
    n_checks++;
    tick();
    if (clean_done !== 1'b0 || mode !== 3'd0) begin
      $display("FAIL abort_hold: cd=%0d mode=%0d expected 0/0", clean_done, mode); n_fail++;
    end
    n_checks++;
    power_state = 1;
    tick();
    if (mode !== 3'd1 || hurricane_used !== 1'b0) begin
      $display("FAIL abort_repower: mode=%0d hu=%0d expected 1/0", mode, hurricane_used); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_priority_reset();
    keys(1, 0, 0, 0, 0);
    keys(0, 0, 0, 1, 1);
    if (mode !== 3'd6 || hurricane_used !== 1'b0) begin
      $display("FAIL prio_clean: mode=%0d hu=%0d expected 6/0", mode, hurricane_used); n_fail++;
    end
    n_checks++;
    power_state = 0;
    tick();
    power_state = 1;
    tick();
    keys(1, 0, 0, 0, 0);
    keys(0, 0, 0, 1, 0);
    tick();
    tick();
    if (mode !== 3'd5) begin $display("FAIL prio_hurr: mode=%0d expected 5", mode); n_fail++; end
    n_checks++;
    #2 reset = 0;
    #1;
    if ({mode, fan_level, clean_active, sec_left, hurricane_used, clean_done} !== 16'h0) begin
      $display("FAIL async_reset: got mode=%0d fan=%0d ca=%0d sec=%0d hu=%0d cd=%0d expected all 0",
               mode, fan_level, clean_active, sec_left, hurricane_used, clean_done);
      n_fail++;
    end
    n_checks++;
    #1 reset = 1;
    tick();
    if (mode !== 3'd1 || sec_left !== 8'd0) begin
      $display("FAIL post_reset: mode=%0d sec=%0d expected 1/0", mode, sec_left); n_fail++;
    end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_power_menu();
    test_hurricane_expiry();
    test_hurricane_early();
    test_clean();
    test_abort();
    test_priority_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hood_mode_scheduler.md
Name: hood_mode_scheduler

Overview:
Sequences the range-hood fan motor once the gesture power block has turned the unit on. It takes debounced single-cycle key pulses and `power_state` from the power controller. It runs the mode state machine: standby, menu, extraction levels 1/2, hurricane, self-clean and cooldown. Each mode has its own per-second timers, and the block drives the fan level and the clean actuator.

Parameters:
TICKS_PER_SEC, 100000000, clk cycles per one-second tick
HURRICANE_SEC, 60, hurricane duration in seconds (1..255)
CLEAN_SEC, 180, self-clean duration in seconds (1..255)
COOLDOWN_SEC, 60, delay after leaving hurricane before standby (1..255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
power_state  in  1  1 = unit on (from power controller)
menu_key  in  1  one-cycle pulse
level1_key  in  1  one-cycle pulse
level2_key  in  1  one-cycle pulse
level3_key  in  1  one-cycle pulse
clean_key  in  1  one-cycle pulse
mode  out  3  0 OFF, 1 STANDBY, 2 MENU, 3 L1, 4 L2, 5 HURRICANE, 6 CLEAN, 7 COOLDOWN
fan_level  out  2  0 off, 1..3 speed
clean_active  out  1  clean actuator enable
sec_left  out  8  remaining seconds of the active timer, 0 when untimed
hurricane_used  out  1  hurricane consumed in this power-on session
clean_done  out  1  one-cycle pulse when a clean completes

Behaviour:
- All outputs are registered.
- Reset (reset=0, async) gives:
  - mode=OFF, fan_level=0, clean_active=0, sec_left=0, hurricane_used=0, clean_done=0
  - internal tick_cnt=0
- power_state=0 in any state forces OFF on the next edge. It also clears sec_left, tick_cnt and hurricane_used, and aborts clean without a clean_done pulse. This overrides every key.
- OFF with power_state=1 goes to STANDBY next edge.
- STANDBY: menu_key goes to MENU. Other keys are ignored.
- MENU:
  - Key priority: clean_key > level3_key > level2_key > level1_key > menu_key.
  - clean_key goes to CLEAN with sec_left=CLEAN_SEC.
  - level3_key with hurricane_used=0 goes to HURRICANE with sec_left=HURRICANE_SEC and sets hurricane_used.
  - level3_key with hurricane_used=1 is ignored and the block stays in MENU; lower-priority keys in the same cycle are then evaluated.
  - level2_key goes to L2; level1_key goes to L1; menu_key goes to STANDBY.
- L1 / L2:
  - The other level key switches directly between L1 and L2.
  - menu_key goes to STANDBY.
  - level3_key and clean_key are ignored.
- HURRICANE:
  - Timer expiry goes to L2.
  - menu_key goes to COOLDOWN with sec_left=COOLDOWN_SEC; the fan stays at level 3.
  - Other keys are ignored.
- COOLDOWN: expiry goes to STANDBY. All keys are ignored.
- CLEAN:
  - Expiry goes to STANDBY and pulses clean_done for exactly 1 cycle, on the same edge that mode becomes STANDBY.
  - All keys are ignored.
- fan_level by mode: L1=1, L2=2, HURRICANE=3, COOLDOWN=3, all others 0. clean_active=1 only in CLEAN.
- Timer rules:
  - Loading a timer sets tick_cnt=0.
  - tick_cnt counts 0..TICKS_PER_SEC-1 and wraps.
  - On wrap with sec_left>0, sec_left decrements.
  - In a timed state with sec_left==0, exit on the next edge.
  - Latency: entry edge E → sec_left reaches 0 at E+N*TICKS_PER_SEC → exit at E+N*TICKS_PER_SEC+1.
  - Outside timed states, tick_cnt and sec_left are held at 0.
- Leaving HURRICANE early via COOLDOWN still leaves hurricane_used=1. Only power-off or reset clears it.
- power_state dropping while a timer is running aborts the timer immediately, regardless of the remaining count.

Test Plan:
TICKS_PER_SEC=4, HURRICANE_SEC=3, CLEAN_SEC=2, COOLDOWN_SEC=2 for all scenarios.
1. Power-up and menu: reset, power_state=1, menu, level1, level2, menu → mode 0→1→2→3→4→1; fan_level 0,0,0,1,2,0.
2. Hurricane expiry: menu, level3 → mode=5, fan_level=3, sec_left 3,2,1,0. mode=4 exactly 13 cycles after entry; hurricane_used=1. A second menu+level3 leaves mode=2.
3. Hurricane early exit: in HURRICANE, menu → mode=7, sec_left=2, fan_level=3. Keys during cooldown are ignored. mode=1 after 9 cycles.
4. Clean: menu, clean_key → mode=6, clean_active=1 for 9 cycles. clean_done is high for 1 cycle as mode becomes 1; clean_active then 0.
5. Abort: in CLEAN with sec_left=1, power_state=0 → next edge mode=0, clean_active=0, sec_left=0, no clean_done. Power back on gives mode=1, hurricane_used=0.
6. Priority and async reset: in MENU, clean_key and level3_key in the same cycle → mode=6. Assert reset mid-HURRICANE between edges → all outputs zero immediately.
